// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Lookup is purely combinational on pc; updates from the resolve stage
// are written at the clock edge and become visible on the next cycle.
module btb_predictor #(
  parameter int WORD_SIZE = 16,
  parameter int ENTRIES   = 16,
  localparam int IDX_W    = $clog2(ENTRIES),
  localparam int TAG_W    = WORD_SIZE - IDX_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] pc,
  output logic                 pred_taken,
  output logic [WORD_SIZE-1:0] pred_target,
  output logic [WORD_SIZE-1:0] next_pc,
  input  logic                 upd_valid,
  input  logic [WORD_SIZE-1:0] upd_pc,
  input  logic                 upd_taken,
  input  logic [WORD_SIZE-1:0] upd_target,
  input  logic                 upd_mispredict,
  output logic [15:0]          mispredict_cnt
);

  // Counter encoding: 00 strongly not-taken .. 11 strongly taken.
  localparam logic [1:0] CTR_SN = 2'b00;
  localparam logic [1:0] CTR_WN = 2'b01;
  localparam logic [1:0] CTR_WT = 2'b10;
  localparam logic [1:0] CTR_ST = 2'b11;

  logic                 valid_q  [ENTRIES];
  logic [TAG_W-1:0]     tag_q    [ENTRIES];
  logic [WORD_SIZE-1:0] target_q [ENTRIES];
  logic [1:0]           ctr_q    [ENTRIES];

  logic [IDX_W-1:0] look_idx;
  logic [TAG_W-1:0] look_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             look_hit;
  logic             upd_hit;

  assign look_idx = pc[IDX_W-1:0];
  assign look_tag = pc[WORD_SIZE-1:IDX_W];
  assign upd_idx  = upd_pc[IDX_W-1:0];
  assign upd_tag  = upd_pc[WORD_SIZE-1:IDX_W];

  // Fetch-side lookup: reads the registered table only, so an update in
  // the same cycle is not bypassed into the prediction.
  always_comb begin
    look_hit    = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
    pred_taken  = look_hit && ctr_q[look_idx][1];
    pred_target = look_hit ? target_q[look_idx] : '0;
    next_pc     = pred_taken ? pred_target : pc + {{(WORD_SIZE-1){1'b0}}, 1'b1};
  end

  // Resolve-side hit detection for the entry being trained.
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Table training, allocation and misprediction counting; reset wins over
  // any concurrent update and wipes all learned state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WN;
      end
      mispredict_cnt <= 16'h0000;
    end else if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          target_q[upd_idx] <= upd_target;
          if (ctr_q[upd_idx] != CTR_ST) begin
            ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
          end
        end else if (ctr_q[upd_idx] != CTR_SN) begin
          ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target;
        ctr_q[upd_idx]    <= CTR_WT;
      end
      if (upd_mispredict && (mispredict_cnt != 16'hFFFF)) begin
        mispredict_cnt <= mispredict_cnt + 16'd1;
      end
    end
  end

endmodule

// File: doc/btb_predictor.md
BTB_PREDICTOR -- requirements
Module: btb_predictor

Interface
REQ-001 The block SHALL expose parameter WORD_SIZE, default 16, the PC and target width in bits.
REQ-002 The block SHALL expose parameter ENTRIES, default 16, the direct-mapped table depth (power of two, 2..256).
REQ-003 The block SHALL expose derived parameters IDX_W = log2(ENTRIES) and TAG_W = WORD_SIZE - IDX_W.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 pc  input  WORD_SIZE  fetch-stage PC to predict for.
REQ-007 pred_taken  output  1  the lookup hit and its counter predicts taken.
REQ-008 pred_target  output  WORD_SIZE  target stored in the indexed entry (0 when no hit).
REQ-009 next_pc  output  WORD_SIZE  predicted fetch PC.
REQ-010 upd_valid  input  1  a resolved control instruction (BNE/BEQ/BGZ/BLZ/JMP/JAL) is reported this cycle.
REQ-011 upd_pc  input  WORD_SIZE  PC of the resolved instruction.
REQ-012 upd_taken  input  1  actual branch outcome.
REQ-013 upd_target  input  WORD_SIZE  actual target computed as PC + offset.
REQ-014 upd_mispredict  input  1  the pipeline flushed for this instruction.
REQ-015 mispredict_cnt  output  16  saturating count of reported mispredictions.

Function
REQ-016 Index SHALL be pc[IDX_W-1:0] and tag SHALL be pc[WORD_SIZE-1:IDX_W]; the same split SHALL apply to upd_pc.
REQ-017 Each entry SHALL hold a valid bit, a TAG_W tag, a WORD_SIZE target and a 2-bit counter (00 SN, 01 WN, 10 WT, 11 ST).
REQ-018 Lookup SHALL be combinational, with zero-cycle latency: hit = valid & (tag match).
REQ-019 pred_taken SHALL be hit & counter[1].
REQ-020 next_pc SHALL be pred_target when pred_taken is 1, and otherwise pc + 1 modulo 2^WORD_SIZE (pc all-ones wraps to 0).
REQ-021 On update to a hit entry, the counter SHALL increment when upd_taken is 1 and decrement when it is 0.
    - Increment saturates at 11.
    - Decrement saturates at 00.
REQ-022 On update to a hit entry with upd_taken = 1, the target SHALL be overwritten with upd_target.
REQ-023 On update to a missing entry with upd_taken = 1, the block SHALL allocate or replace the entry: valid = 1, new tag, target = upd_target, counter = 10.
REQ-024 On update to a missing entry with upd_taken = 0, the table SHALL remain unchanged.
REQ-025 Table writes SHALL take effect at the clock edge that samples upd_valid; a lookup in the same cycle SHALL see the pre-update contents (no bypass), and the new contents SHALL be visible from the next cycle.
REQ-026 When upd_valid is 0, the table and the counter SHALL hold their values, and upd_taken, upd_target and upd_mispredict SHALL be ignored.
REQ-027 mispredict_cnt SHALL increment on each edge where upd_valid & upd_mispredict is 1, saturating at 16'hFFFF.
REQ-028 Unknown or X values on pc while reset_n = 0 SHALL NOT corrupt any state.

Reset
REQ-029 While reset_n = 0 at an edge, every entry SHALL be cleared: valid = 0, tag = 0, target = 0, counter = 01.
REQ-030 Reset SHALL also clear mispredict_cnt to 0, and it overrides any concurrent update.
REQ-031 After reset, the outputs SHALL be pred_taken = 0, pred_target = 0 and next_pc = pc + 1.
REQ-032 Reset asserted mid-operation SHALL discard all learned state at that edge.

Verification
REQ-033 Cold lookup: reset, then pc = 16'h0010 -> pred_taken = 0, next_pc = 16'h0011.
REQ-034 Allocate and predict: update upd_pc = 16'h0023, taken, target = 16'h0040; next cycle pc = 16'h0023 -> pred_taken = 1, next_pc = 16'h0040.
REQ-035 Hysteresis: two not-taken updates on 16'h0023 take the counter 10 -> 01 -> 00 -> pred_taken = 0; one taken update (counter 01) -> still 0; a second taken update -> 1.
REQ-036 Alias: with entry 16'h0023 valid, lookup pc = 16'h0033 (same index, different tag) -> miss, next_pc = 16'h0034; a taken update on 16'h0033 replaces the entry, after which 16'h0023 misses.
REQ-037 Same-cycle hazard and wrap: the allocate update and the lookup of the same PC in one cycle -> that cycle predicts not-taken and the next cycle predicts taken; pc = 16'hFFFF with a miss -> next_pc = 16'h0000.
REQ-038 Counter: 3 cycles of upd_valid & upd_mispredict, then reset_n low for 1 cycle -> mispredict_cnt reads 3, then 0.
